// File: rtl/conv_img_stream_feeder_pkg.sv
// Shared constants and state encoding for the conv3d input pixel-stream feeder.
package conv_img_stream_feeder_pkg;

    localparam int NUM_CH         = 3;
    localparam int DEF_IMG_WIDTH  = 56;
    localparam int DEF_IMG_HEIGHT = 56;
    localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } feeder_state_t;

    // Frame size for a non-default geometry chosen at instantiation time.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/conv_img_stream_feeder_frame_ram.sv
// One channel of frame storage: simple dual-port RAM, one write port and one
// synchronous read port. Contents are deliberately not reset.
module frame_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/conv_img_stream_feeder.sv
// Frame buffer and raster streamer feeding the 3-channel conv3d input.
// Host loads the three channel buffers while idle; start replays the frame.
module conv_img_stream_feeder
    import conv_img_stream_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_wr_en,
    input  logic [1:0]            i_wr_ch,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_err,
    input  logic                  i_start,
    input  logic                  i_pause,
    output logic                  o_busy,
    output logic                  o_data_valid_out,
    output logic [DATA_WIDTH-1:0] o_data_out0,
    output logic [DATA_WIDTH-1:0] o_data_out1,
    output logic [DATA_WIDTH-1:0] o_data_out2,
    output logic                  o_frame_done
);

    localparam int                    N_PIX    = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(N_PIX - 1);

    feeder_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_err;
    logic                  r_vld_p1;
    logic                  r_last_p1;
    logic                  r_vld_p2;
    logic                  r_last_p2;
    logic [DATA_WIDTH-1:0] r_data_p2  [NUM_CH];
    logic [DATA_WIDTH-1:0] w_rdata_p1 [NUM_CH];
    logic                  w_issue;
    logic                  w_wr_ok;

    // Writes are only legal while idle, so a write never races a stream read.
    assign w_wr_ok = i_wr_en && (r_state == ST_IDLE) && (i_wr_ch != 2'd3)
                     && (i_wr_addr <= LAST_PIX);
    assign w_issue = (r_state == ST_STREAM) && !i_pause;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        frame_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_frame_ram (
            .clk    (clk),
            .i_we   (w_wr_ok && (i_wr_ch == 2'(ch))),
            .i_waddr(i_wr_addr),
            .i_wdata(i_wr_data),
            .i_re   (w_issue),
            .i_raddr(r_rd_addr),
            .o_rdata(w_rdata_p1[ch])
        );
    end

    // Stage p0 -> p1: read issue, address sequencing, write rejection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_rd_addr <= '0;
            r_wr_err  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_wr_err  <= i_wr_en && !w_wr_ok;
            r_vld_p1  <= w_issue;
            r_last_p1 <= w_issue && (r_rd_addr == LAST_PIX);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_STREAM;
                        r_rd_addr <= '0;
                    end
                end
                ST_STREAM: begin
                    if (!i_pause) begin
                        if (r_rd_addr == LAST_PIX) begin
                            r_state   <= ST_IDLE;
                            r_rd_addr <= '0;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1 -> p2: output register; pixel words hold while no read lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_data_p2[c] <= '0;
            end
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            if (r_vld_p1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_data_p2[c] <= w_rdata_p1[c];
                end
            end
        end
    end

    assign o_busy           = (r_state == ST_STREAM);
    assign o_wr_err         = r_wr_err;
    assign o_data_valid_out = r_vld_p2;
    assign o_frame_done     = r_last_p2;
    assign o_data_out0      = r_data_p2[0];
    assign o_data_out1      = r_data_p2[1];
    assign o_data_out2      = r_data_p2[2];

endmodule

// File: tb/tb_conv_img_stream_feeder.sv
// Directed scoreboard bench for conv_img_stream_feeder at the default 56x56 geometry.
module tb_conv_img_stream_feeder;
    import conv_img_stream_feeder_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 12;
    localparam int NPIX = FRAME_PIXELS;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          i_wr_en   = 1'b0;
    logic [1:0]    i_wr_ch   = 2'd0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_start   = 1'b0;
    logic          i_pause   = 1'b0;
    logic          o_wr_err, o_busy, o_data_valid_out, o_frame_done;
    logic [DW-1:0] o_data_out0, o_data_out1, o_data_out2;

    always #5 clk = ~clk;

    conv_img_stream_feeder #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (DEF_IMG_WIDTH),
        .IMG_HEIGHT(DEF_IMG_HEIGHT),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_wr_en         (i_wr_en),
        .i_wr_ch         (i_wr_ch),
        .i_wr_addr       (i_wr_addr),
        .i_wr_data       (i_wr_data),
        .o_wr_err        (o_wr_err),
        .i_start         (i_start),
        .i_pause         (i_pause),
        .o_busy          (o_busy),
        .o_data_valid_out(o_data_valid_out),
        .o_data_out0     (o_data_out0),
        .o_data_out1     (o_data_out1),
        .o_data_out2     (o_data_out2),
        .o_frame_done    (o_frame_done)
    );

    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          last;
        logic [15:0]   idx;
    } pix_t;

    pix_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0, first_cyc, done_cyc, gaps, pix_cnt, d1;
    int   done_cnt = 0;
    int   last_idx = -1;
    bit   in_frame = 1'b0;
    logic done_busy;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and scored against the queue.
    task automatic tick();
        pix_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (o_data_valid_out) begin
            if (exp_q.size() == 0) begin
                check1("unexpected_pixel", o_data_valid_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("data_out0", o_data_out0, e.d0);
                check("data_out1", o_data_out1, e.d1);
                check("data_out2", o_data_out2, e.d2);
                check1("frame_done", o_frame_done, e.last);
                pix_cnt++;
                last_idx = int'(e.idx);
                if (e.idx == 16'd0) begin
                    first_cyc = cyc;
                    in_frame  = 1'b1;
                end
                if (e.last) begin
                    done_cyc  = cyc;
                    done_busy = o_busy;
                    done_cnt++;
                    in_frame  = 1'b0;
                end
            end
        end else begin
            check1("frame_done_without_pixel", o_frame_done, 1'b0);
            if (in_frame) gaps++;
        end
    endtask

    task automatic host_write(input logic [1:0] ch, input logic [AW-1:0] addr,
                              input logic [DW-1:0] d, input logic exp_err);
        i_wr_en   = 1'b1;
        i_wr_ch   = ch;
        i_wr_addr = addr;
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
        check1("wr_err", o_wr_err, exp_err);
    endtask

    task automatic push_frame();
        pix_t e;
        for (int n = 0; n < NPIX; n++) begin
            e.d0   = DW'(n);
            e.d1   = DW'(4096 + n);
            e.d2   = DW'(8192 + n);
            e.last = (n == NPIX - 1);
            e.idx  = 16'(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        push_frame();
        pix_cnt = 0;
        gaps    = 0;
        i_start = 1'b1;
        tick();
        t0      = cyc;
        i_start = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check1("frame_timeout", done_cnt >= target, 1'b1);
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int n = 0;
        while (last_idx != idx && n < budget) begin
            tick();
            n++;
        end
        check("wait_pixel_idx", DW'(last_idx), DW'(idx));
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_busy"}, o_busy, 1'b0);
        check1({tag, "_valid"}, o_data_valid_out, 1'b0);
        check1({tag, "_done"}, o_frame_done, 1'b0);
        check1({tag, "_wr_err"}, o_wr_err, 1'b0);
        check({tag, "_d0"}, o_data_out0, '0);
        check({tag, "_d1"}, o_data_out1, '0);
        check({tag, "_d2"}, o_data_out2, '0);
    endtask

    initial begin
        int base, n;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        resetn = 1'b1;
        tick();

        // Load channel k with k*4096 + index
        for (int p = 0; p < NPIX; p++) begin
            for (int k = 0; k < 3; k++) begin
                host_write(2'(k), AW'(p), DW'(k * 4096 + p), 1'b0);
            end
        end

        // Plain frame: latency, length, frame_done placement
        start_frame();
        check1("busy_after_start", o_busy, 1'b1);
        run_until(done_cnt + 1, NPIX + 20);
        check("first_pixel_cycle", DW'(first_cyc), DW'(t0 + 2));
        check("frame_done_cycle", DW'(done_cyc), DW'(t0 + NPIX + 1));
        check("frame1_pixels", DW'(pix_cnt), DW'(NPIX));
        check("frame1_gaps", DW'(gaps), 32'd0);
        check1("busy_at_frame_done", done_busy, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check1("idle_after_frame", o_busy, 1'b0);
        check("hold_d2_after_frame", o_data_out2, DW'(8192 + NPIX - 1));

        // Pause for 5 cycles at pixel 100
        start_frame();
        wait_idx(99, 200);
        i_pause = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_pause = 1'b0;
        run_until(done_cnt + 1, NPIX + 30);
        check("pause_gaps", DW'(gaps), 32'd5);
        check("pause_pixels", DW'(pix_cnt), DW'(NPIX));

        // Illegal writes while idle
        host_write(2'd3, AW'(7), 32'hBAD0_0003, 1'b1);
        host_write(2'd0, AW'(NPIX), 32'hBAD0_0C40, 1'b1);
        tick();
        check1("wr_err_pulse_ends", o_wr_err, 1'b0);

        // Write during busy plus a stray start pulse; replay must be unchanged
        start_frame();
        for (int i = 0; i < 10; i++) tick();
        host_write(2'd0, AW'(5), 32'hDEAD_BEEF, 1'b1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check1("wr_err_busy_ends", o_wr_err, 1'b0);
        run_until(done_cnt + 1, NPIX + 20);
        check("replay_pixels", DW'(pix_cnt), DW'(NPIX));
        for (int i = 0; i < 6; i++) tick();
        check1("no_queued_start", o_busy, 1'b0);
        check("queue_empty_replay", DW'(exp_q.size()), 32'd0);

        // Start held high: back-to-back frames
        base    = done_cnt;
        pix_cnt = 0;
        push_frame();
        push_frame();
        i_start = 1'b1;
        n = 0;
        while (done_cnt < base + 1 && n < NPIX + 20) begin
            tick();
            n++;
        end
        d1 = done_cyc;
        n = 0;
        while (first_cyc <= d1 && n < 10) begin
            tick();
            n++;
        end
        i_start = 1'b0;
        check("b2b_next_pixel0", DW'(first_cyc), DW'(d1 + 2));
        run_until(base + 2, NPIX + 20);
        check("b2b_pixels", DW'(pix_cnt), DW'(2 * NPIX));
        for (int i = 0; i < 4; i++) tick();
        check1("idle_after_b2b", o_busy, 1'b0);

        // Reset mid-frame at pixel 1500
        start_frame();
        wait_idx(1500, 1600);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("midreset");
        exp_q.delete();
        in_frame = 1'b0;
        tick();
        check_idle_outputs("held_reset");
        resetn = 1'b1;
        tick();
        start_frame();
        run_until(done_cnt + 1, NPIX + 20);
        check("post_reset_first", DW'(first_cyc), DW'(t0 + 2));
        check("post_reset_pixels", DW'(pix_cnt), DW'(NPIX));
        for (int i = 0; i < 4; i++) tick();
        check("queue_empty_end", DW'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
